// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM device model with command decode, storage and CAS-latency reads; checker built when SDRAM_RESP_CHECK_EN is defined
module sdram_responder #(
  parameter int MEM_AW  = 12,
  parameter int RCD_MIN = 2
) (
  input  logic        clk,
  input  logic        init,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [10:0] sd_addr,
  input  logic        sd_ba,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_data_out,
  input  logic        sd_data_dir,
  output logic [15:0] sd_data_in,
  output logic        rd_strobe,
  output logic [10:0] mode_reg,
  output logic        mode_valid,
  output logic [15:0] refresh_count,
  output logic        proto_err,
  output logic [2:0]  err_code
);

  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;

  logic [3:0]  cmd;
  logic        is_lmr, is_ref, is_pre, is_act, is_wr, is_rd;
  logic        lmr_legal;

  assign cmd    = {sd_cs, sd_ras, sd_cas, sd_we};
  assign is_lmr = (cmd == CMD_LMR);
  assign is_ref = (cmd == CMD_REF);
  assign is_pre = (cmd == CMD_PRE);
  assign is_act = (cmd == CMD_ACT);
  assign is_wr  = (cmd == CMD_WR);
  assign is_rd  = (cmd == CMD_RD);

  // Only burst-length 1 with CL 2 or 3 is a mode this model can honour.
  assign lmr_legal = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) &&
                     (sd_addr[2:0] == 3'b000);

  // Per-bank state and the read pipeline (two stages plus the output register).
  logic [1:0]  bank_active;
  logic [10:0] open_row [2];
  logic        cl3;
  logic [1:0]  pipe_vld;
  logic [15:0] pipe_data [2];

  // Word index {ba, low row bits, col}; row bits above MEM_AW-10 alias.
  function automatic logic [MEM_AW-1:0] word_index(input logic ba,
                                                   input logic [10:0] row,
                                                   input logic [7:0] col);
    logic [10:0] row_bits;
    logic [19:0] full;
    row_bits = row & 11'((1 << (MEM_AW - 9)) - 1);
    full     = (20'(ba) << (MEM_AW - 1)) | (20'(row_bits) << 8) | 20'(col);
    return MEM_AW'(full);
  endfunction

  logic [15:0]       mem [0:(1 << MEM_AW) - 1];
  logic [MEM_AW-1:0] acc_idx;
  logic [15:0]       rd_word;
  logic [15:0]       rd_masked;

  assign acc_idx   = word_index(sd_ba, open_row[sd_ba], sd_addr[7:0]);
  assign rd_word   = mem[acc_idx];
  assign rd_masked = {sd_dqm[1] ? 8'h00 : rd_word[15:8],
                      sd_dqm[0] ? 8'h00 : rd_word[7:0]};

  // Storage array: byte-masked write at the command edge, never reset.
  always_ff @(posedge clk) begin
    if (is_wr) begin
      if (!sd_dqm[0]) mem[acc_idx][7:0]  <= sd_data_out[7:0];
      if (!sd_dqm[1]) mem[acc_idx][15:8] <= sd_data_out[15:8];
    end
  end

  // Command execution, mode register and the CAS-latency read pipeline.
  // CL defaults to 2 until a LOAD_MODE selects otherwise.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      bank_active   <= 2'b00;
      open_row[0]   <= 11'd0;
      open_row[1]   <= 11'd0;
      cl3           <= 1'b0;
      mode_reg      <= 11'd0;
      mode_valid    <= 1'b0;
      refresh_count <= 16'd0;
      pipe_vld      <= 2'b00;
      pipe_data[0]  <= 16'd0;
      pipe_data[1]  <= 16'd0;
      sd_data_in    <= 16'd0;
      rd_strobe     <= 1'b0;
    end else begin
      pipe_vld[0]  <= is_rd;
      pipe_data[0] <= rd_masked;
      pipe_vld[1]  <= pipe_vld[0];
      pipe_data[1] <= pipe_data[0];
      rd_strobe    <= cl3 ? pipe_vld[1] : pipe_vld[0];
      if (cl3 ? pipe_vld[1] : pipe_vld[0])
        sd_data_in <= cl3 ? pipe_data[1] : pipe_data[0];

      if (is_pre) begin
        if (sd_addr[10]) bank_active <= 2'b00;
        else             bank_active[sd_ba] <= 1'b0;
      end
      if (is_act) begin
        open_row[sd_ba]    <= sd_addr;
        bank_active[sd_ba] <= 1'b1;
      end
      if ((is_rd || is_wr) && sd_addr[10])
        bank_active[sd_ba] <= 1'b0;
      if (is_ref)
        refresh_count <= refresh_count + 16'd1;
      if (is_lmr && lmr_legal) begin
        mode_reg   <= sd_addr;
        mode_valid <= 1'b1;
        cl3        <= sd_addr[4];
      end
    end
  end

`ifdef SDRAM_RESP_CHECK_EN
  localparam int RCD_W = (RCD_MIN < 1) ? 1 : $clog2(RCD_MIN + 1);

  logic [RCD_W-1:0] rcd_cnt [2];
  logic [2:0]       chk_code;
  logic [2:0]       err_pend;
  logic             rcd_ok;
  logic             is_bst;

  assign is_bst = (cmd == 4'b0110);
  // A counter value of n means n+1 clocks have elapsed since ACTIVE.
  assign rcd_ok = (int'(rcd_cnt[sd_ba]) + 1) >= RCD_MIN;

  // Classify the sampled command; the first matching rule wins.
  always_comb begin
    chk_code = 3'd0;
    if (is_rd || is_wr) begin
      if (!mode_valid)                chk_code = 3'd1;
      else if (!bank_active[sd_ba])   chk_code = 3'd3;
      else if (!rcd_ok)               chk_code = 3'd4;
      else if (is_wr && !sd_data_dir) chk_code = 3'd7;
    end else if (is_act) begin
      if (!mode_valid)                chk_code = 3'd1;
      else if (bank_active[sd_ba])    chk_code = 3'd2;
    end else if (is_ref) begin
      if (|bank_active)               chk_code = 3'd5;
    end else if (is_lmr) begin
      if (|bank_active)               chk_code = 3'd5;
      else if (!lmr_legal)            chk_code = 3'd6;
    end else if (is_bst) begin
      chk_code = 3'd6;
    end
  end

  // Per-bank tRCD counters: cleared by ACTIVE, saturate at RCD_MIN.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int b = 0; b < 2; b++) rcd_cnt[b] <= RCD_W'(RCD_MIN);
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (is_act && (int'(sd_ba) == b))
          rcd_cnt[b] <= '0;
        else if (rcd_cnt[b] < RCD_W'(RCD_MIN))
          rcd_cnt[b] <= rcd_cnt[b] + 1'b1;
      end
    end
  end

  // Error report lands one edge after the offending command; flag is sticky.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      err_pend  <= 3'd0;
      proto_err <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      err_pend <= chk_code;
      if (err_pend != 3'd0) begin
        proto_err <= 1'b1;
        err_code  <= err_pend;
      end
    end
  end
`else
  logic unused_dir;
  assign unused_dir = sd_data_dir;
  assign proto_err  = 1'b0;
  assign err_code   = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - table-driven bench with read scoreboard for sdram_responder
module tb_sdram_responder;

  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] NOP = 4'b0111;

`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        init = 1'b1;
  logic        sd_cs = 1'b0, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
  logic [10:0] sd_addr = 11'd0;
  logic        sd_ba = 1'b0;
  logic [1:0]  sd_dqm = 2'b00;
  logic [15:0] sd_data_out = 16'd0;
  logic        sd_data_dir = 1'b0;
  logic [15:0] sd_data_in;
  logic        rd_strobe;
  logic [10:0] mode_reg;
  logic        mode_valid;
  logic [15:0] refresh_count;
  logic        proto_err;
  logic [2:0]  err_code;

  sdram_responder dut (
    .clk(clk), .init(init),
    .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
    .sd_addr(sd_addr), .sd_ba(sd_ba), .sd_dqm(sd_dqm),
    .sd_data_out(sd_data_out), .sd_data_dir(sd_data_dir),
    .sd_data_in(sd_data_in), .rd_strobe(rd_strobe),
    .mode_reg(mode_reg), .mode_valid(mode_valid),
    .refresh_count(refresh_count), .proto_err(proto_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct { logic [15:0] data; int due; } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct {
    logic [3:0]  cmd;
    logic [10:0] addr;
    logic        ba;
    logic [1:0]  dqm;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rexp;
    logic        exp_mv;
    logic [10:0] exp_mode;
    logic [15:0] exp_ref;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] c, input logic [10:0] a, input logic b,
                              input logic [1:0] m, input logic [15:0] d, input int lat,
                              input logic [15:0] rexp, input logic mv,
                              input logic [10:0] mode, input logic [15:0] rf);
    vec_t v;
    v.cmd = c; v.addr = a; v.ba = b; v.dqm = m; v.wdata = d; v.lat = lat;
    v.rexp = rexp; v.exp_mv = mv; v.exp_mode = mode; v.exp_ref = rf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one command for exactly one rising edge; returns at the following falling edge.
  task automatic issue(input logic [3:0] c, input logic [10:0] a, input logic b,
                       input logic [1:0] m, input logic [15:0] d);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_addr = a; sd_ba = b; sd_dqm = m; sd_data_out = d;
    sd_data_dir = (c == WR);
    @(posedge clk);
    @(negedge clk);
    {sd_cs, sd_ras, sd_cas, sd_we} = NOP;
    sd_data_dir = 1'b0;
  endtask

  task automatic push_read(input logic [15:0] data, input int lat);
    rd_exp_t e;
    e.data = data;
    e.due  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic run_table(input string tag, input vec_t t[$]);
    for (int i = 0; i < t.size(); i++) begin
      if (t[i].lat != 0) push_read(t[i].rexp, t[i].lat);
      issue(t[i].cmd, t[i].addr, t[i].ba, t[i].dqm, t[i].wdata);
      chk($sformatf("%s[%0d].mode_valid", tag, i), 32'(mode_valid), 32'(t[i].exp_mv));
      chk($sformatf("%s[%0d].mode_reg", tag, i), 32'(mode_reg), 32'(t[i].exp_mode));
      chk($sformatf("%s[%0d].refresh_count", tag, i), 32'(refresh_count), 32'(t[i].exp_ref));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".sd_data_in"}, 32'(sd_data_in), 32'h0);
    chk({tag, ".rd_strobe"}, 32'(rd_strobe), 32'h0);
    chk({tag, ".mode_reg"}, 32'(mode_reg), 32'h0);
    chk({tag, ".mode_valid"}, 32'(mode_valid), 32'h0);
    chk({tag, ".refresh_count"}, 32'(refresh_count), 32'h0);
    chk({tag, ".proto_err"}, 32'(proto_err), 32'h0);
    chk({tag, ".err_code"}, 32'(err_code), 32'h0);
  endtask

  // Scoreboard: every strobe must match the oldest expected read, on its due cycle.
  always @(negedge clk) begin
    rd_exp_t e;
    if (!init) begin
      if (rd_strobe) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got data %0h at cycle %0d expected no strobe", sd_data_in, cyc);
        end else begin
          e = sb.pop_front();
          chk("rd_data", 32'(sd_data_in), 32'(e.data));
          chk("rd_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        e = sb.pop_front();
        chk("rd_missing_strobe", 32'(rd_strobe), 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t ta[$];
    vec_t tb_q[$];

    // CL2 phase: init sequence, write, masked writes and reads.
    ta.push_back(mk(PRE, 11'h400, 1'b0, 2'b00, 16'h0,    0, 16'h0,    1'b0, 11'h000, 16'd0));
    ta.push_back(mk(REF, 11'h000, 1'b0, 2'b00, 16'h0,    0, 16'h0,    1'b0, 11'h000, 16'd1));
    ta.push_back(mk(REF, 11'h000, 1'b0, 2'b00, 16'h0,    0, 16'h0,    1'b0, 11'h000, 16'd2));
    ta.push_back(mk(LMR, 11'h220, 1'b0, 2'b00, 16'h0,    0, 16'h0,    1'b1, 11'h220, 16'd2));
    ta.push_back(mk(ACT, 11'h003, 1'b1, 2'b00, 16'h0,    0, 16'h0,    1'b1, 11'h220, 16'd2));
    ta.push_back(mk(NOP, 11'h000, 1'b0, 2'b00, 16'h0,    0, 16'h0,    1'b1, 11'h220, 16'd2));
    ta.push_back(mk(WR,  11'h45A, 1'b1, 2'b00, 16'hBEEF, 0, 16'h0,    1'b1, 11'h220, 16'd2));
    ta.push_back(mk(ACT, 11'h003, 1'b1, 2'b00, 16'h0,    0, 16'h0,    1'b1, 11'h220, 16'd2));
    ta.push_back(mk(NOP, 11'h000, 1'b0, 2'b00, 16'h0,    0, 16'h0,    1'b1, 11'h220, 16'd2));
    ta.push_back(mk(RD,  11'h05A, 1'b1, 2'b00, 16'h0,    2, 16'hBEEF, 1'b1, 11'h220, 16'd2));
    ta.push_back(mk(WR,  11'h05A, 1'b1, 2'b10, 16'h1234, 0, 16'h0,    1'b1, 11'h220, 16'd2));
    ta.push_back(mk(RD,  11'h05A, 1'b1, 2'b00, 16'h0,    2, 16'hBE34, 1'b1, 11'h220, 16'd2));
    ta.push_back(mk(RD,  11'h05A, 1'b1, 2'b01, 16'h0,    2, 16'hBE00, 1'b1, 11'h220, 16'd2));
    for (int i = 0; i < 3; i++)
      ta.push_back(mk(NOP, 11'h000, 1'b0, 2'b00, 16'h0, 0, 16'h0, 1'b1, 11'h220, 16'd2));

    // CL3 phase: latency change, back-to-back reads, row aliasing above MEM_AW-10.
    tb_q.push_back(mk(PRE, 11'h400, 1'b0, 2'b00, 16'h0, 0, 16'h0,    1'b1, 11'h220, 16'd2));
    tb_q.push_back(mk(LMR, 11'h230, 1'b0, 2'b00, 16'h0, 0, 16'h0,    1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(ACT, 11'h003, 1'b1, 2'b00, 16'h0, 0, 16'h0,    1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(NOP, 11'h000, 1'b0, 2'b00, 16'h0, 0, 16'h0,    1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(RD,  11'h05A, 1'b1, 2'b00, 16'h0, 3, 16'hBE34, 1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(RD,  11'h05A, 1'b1, 2'b10, 16'h0, 3, 16'h0034, 1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(PRE, 11'h000, 1'b1, 2'b00, 16'h0, 0, 16'h0,    1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(ACT, 11'h00B, 1'b1, 2'b00, 16'h0, 0, 16'h0,    1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(NOP, 11'h000, 1'b0, 2'b00, 16'h0, 0, 16'h0,    1'b1, 11'h230, 16'd2));
    tb_q.push_back(mk(RD,  11'h05A, 1'b1, 2'b00, 16'h0, 3, 16'hBE34, 1'b1, 11'h230, 16'd2));
    for (int i = 0; i < 4; i++)
      tb_q.push_back(mk(NOP, 11'h000, 1'b0, 2'b00, 16'h0, 0, 16'h0, 1'b1, 11'h230, 16'd2));

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    init = 1'b0;
    @(negedge clk);

    run_table("cl2", ta);
    chk("cl2.sb_drained", 32'(sb.size()), 32'd0);
    chk("cl2.data_hold", 32'(sd_data_in), 32'hBE00);
    chk("cl2.strobe_idle", 32'(rd_strobe), 32'h0);
    chk("cl2.proto_err", 32'(proto_err), 32'h0);
    chk("cl2.err_code", 32'(err_code), 32'h0);

    run_table("cl3", tb_q);
    chk("cl3.sb_drained", 32'(sb.size()), 32'd0);
    chk("cl3.proto_err", 32'(proto_err), 32'h0);

    // Reset asserted before E0+1 of a CL3 read: the data must never appear.
    issue(RD, 11'h05A, 1'b1, 2'b00, 16'h0);
    init = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst.strobe_in_reset", 32'(rd_strobe), 32'h0);
    end
    check_reset_outputs("midrst");
    init = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst.strobe_after", 32'(rd_strobe), 32'h0);
    end

    // Protocol errors from a fresh reset (mode not yet loaded, CL back to 2).
    push_read(16'h0000, 2);
    issue(RD, 11'h05A, 1'b0, 2'b11, 16'h0);
    issue(NOP, 11'h000, 1'b0, 2'b00, 16'h0);
    issue(NOP, 11'h000, 1'b0, 2'b00, 16'h0);
    chk("err.rd_no_mode.code", 32'(err_code), CHK ? 32'd1 : 32'd0);
    chk("err.rd_no_mode.flag", 32'(proto_err), CHK ? 32'd1 : 32'd0);

    issue(LMR, 11'h220, 1'b0, 2'b00, 16'h0);
    issue(ACT, 11'h001, 1'b0, 2'b00, 16'h0);
    push_read(16'h0000, 2);
    issue(RD, 11'h05A, 1'b0, 2'b11, 16'h0);
    issue(NOP, 11'h000, 1'b0, 2'b00, 16'h0);
    issue(NOP, 11'h000, 1'b0, 2'b00, 16'h0);
    chk("err.trcd.code", 32'(err_code), CHK ? 32'd4 : 32'd0);
    chk("err.trcd.flag", 32'(proto_err), CHK ? 32'd1 : 32'd0);

    issue(REF, 11'h000, 1'b0, 2'b00, 16'h0);
    issue(NOP, 11'h000, 1'b0, 2'b00, 16'h0);
    issue(NOP, 11'h000, 1'b0, 2'b00, 16'h0);
    chk("err.ref_open.code", 32'(err_code), CHK ? 32'd5 : 32'd0);
    chk("err.ref_open.flag", 32'(proto_err), CHK ? 32'd1 : 32'd0);
    chk("err.ref_open.count", 32'(refresh_count), 32'd1);
    chk("err.mode_reg", 32'(mode_reg), 32'h220);

    repeat (3) issue(NOP, 11'h000, 1'b0, 2'b00, 16'h0);
    chk("end.sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
